clock_ctrl: RTL

Sequencer and configuration front-end for clock_gen. Accepts commands from the host/debug interface and drives clock_gen's wr_clk_sel and wr_conf strobes. Controls the debug-clock run enable: free-run, halt, or step N cycles. Quiesces the debug clock before any clock-select change so clock_gen never switches sources while the core is clocked.

---
 rtl/clock_ctrl_pkg.sv | 30 +++
 rtl/clock_ctrl_cnt.sv | 31 +++
 rtl/clock_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared encodings and defaults for the clock_gen sequencer front-end.
package clock_ctrl_pkg;

  localparam logic [1:0] OP_HALT = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_CONF = 2'd3;

  localparam int GUARD_CYC_DEF  = 4;
  localparam int SETTLE_CYC_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_Q_PRE  = 3'd3,
    ST_SEL    = 3'd4,
    ST_CONF   = 3'd5,
    ST_SETTLE = 3'd6,
    ST_Q_POST = 3'd7
  } state_e;

  // Counters are loaded with (cycles - 1), so they only need to hold max-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clock_ctrl_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, saturates at zero.
module clock_ctrl_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_ctrl.sv
// Command sequencer for clock_gen: run/halt/step of the debug clock, quiesced clock-select writes.
// Optional CLOCK_CTRL_EXT_RUN_EN: gate run_en with ext_run_en and count only enabled step cycles.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int GUARD_CYC  = GUARD_CYC_DEF,
  parameter int STEP_W     = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic        ext_run_en,
  output logic        run_en,
  output logic        wr_clk_sel,
  output logic        wr_conf,
  output logic [31:0] conf_data,
  output logic        busy,
  output logic        step_done
);

  localparam int GW = cnt_width(GUARD_CYC, SETTLE_CYC);

  state_e      state_q, state_d;
  logic        resume_run_q, resume_run_d;
  logic [31:0] conf_q, conf_d;
  logic        done_d;
  logic        run_en_q, wr_clk_sel_q, wr_conf_q, busy_q, cmd_ready_q, step_done_q;

  logic              step_ld, step_dec, step_zero, step_en;
  logic [STEP_W-1:0] step_val;
  logic              grd_ld, grd_dec, grd_zero;
  logic [GW-1:0]     grd_val;
  logic              accept;

`ifdef CLOCK_CTRL_EXT_RUN_EN
  assign step_en = ext_run_en;
  assign run_en  = run_en_q & ext_run_en;
`else
  // External qualifier has no effect in this build.
  assign step_en = 1'b1 | ext_run_en;
  assign run_en  = run_en_q;
`endif

  assign accept = cmd_valid & cmd_ready_q;

  always_comb begin
    state_d      = state_q;
    resume_run_d = resume_run_q;
    conf_d       = conf_q;
    done_d       = 1'b0;
    step_ld      = 1'b0;
    step_val     = cmd_data[STEP_W-1:0] - STEP_W'(1);
    step_dec     = 1'b0;
    grd_ld       = 1'b0;
    grd_val      = GW'(GUARD_CYC - 1);
    grd_dec      = 1'b0;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) begin
          case (cmd_op)
            OP_HALT: state_d = ST_IDLE;
            OP_RUN:  state_d = ST_RUN;
            OP_STEP: begin
              if (cmd_data[STEP_W-1:0] == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_STEP;
                step_ld = 1'b1;
              end
            end
            default: begin
              state_d      = ST_Q_PRE;
              conf_d       = cmd_data;
              resume_run_d = (state_q == ST_RUN);
              grd_ld       = 1'b1;
            end
          endcase
        end
      end
      ST_STEP: begin
        step_dec = step_en;
        if (step_zero && step_en) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_Q_PRE: begin
        grd_dec = 1'b1;
        if (grd_zero) state_d = ST_SEL;
      end
      ST_SEL: state_d = ST_CONF;
      ST_CONF: begin
        state_d = ST_SETTLE;
        grd_ld  = 1'b1;
        grd_val = GW'(SETTLE_CYC - 1);
      end
      ST_SETTLE: begin
        grd_dec = 1'b1;
        if (grd_zero) begin
          state_d = ST_Q_POST;
          grd_ld  = 1'b1;
        end
      end
      ST_Q_POST: begin
        grd_dec = 1'b1;
        if (grd_zero) state_d = resume_run_q ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each appears one cycle after its cause.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resume_run_q <= 1'b0;
      conf_q       <= '0;
      run_en_q     <= 1'b0;
      wr_clk_sel_q <= 1'b0;
      wr_conf_q    <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      step_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_run_q <= resume_run_d;
      conf_q       <= conf_d;
      run_en_q     <= (state_d == ST_RUN) || (state_d == ST_STEP);
      wr_clk_sel_q <= (state_d == ST_SEL);
      wr_conf_q    <= (state_d == ST_CONF);
      busy_q       <= !((state_d == ST_IDLE) || (state_d == ST_RUN));
      cmd_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_RUN);
      step_done_q  <= done_d;
    end
  end

  clock_ctrl_cnt #(.W(STEP_W)) u_step_cnt (
    .clk_i      (clk_in),
    .rst_i      (reset),
    .load_i     (step_ld),
    .load_val_i (step_val),
    .dec_en_i   (step_dec),
    .zero_o     (step_zero)
  );

  clock_ctrl_cnt #(.W(GW)) u_grd_cnt (
    .clk_i      (clk_in),
    .rst_i      (reset),
    .load_i     (grd_ld),
    .load_val_i (grd_val),
    .dec_en_i   (grd_dec),
    .zero_o     (grd_zero)
  );

  assign cmd_ready  = cmd_ready_q;
  assign wr_clk_sel = wr_clk_sel_q;
  assign wr_conf    = wr_conf_q;
  assign conf_data  = conf_q;
  assign busy       = busy_q;
  assign step_done  = step_done_q;

endmodule
